// File: rtl/bram_pkg.sv
// Shared types and sizing helpers for the simple-dual-port table RAM.
// Holds the fill-engine state encoding and the address-width-to-depth helper.
package bram_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

    localparam int unsigned DEFAULT_ADDR_WIDTH = 9;

    function automatic int unsigned depth_of(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

    localparam int unsigned DEPTH = depth_of(DEFAULT_ADDR_WIDTH);

endpackage

// File: rtl/bram_sdp_if.sv
// Table-RAM bus: loader write port, lookup read port and fill control.
// master = client driving writes/reads/clear, slave = the RAM.
interface bram_sdp_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8
) ();

    logic                  clear;
    logic                  busy;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] din;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;

    modport master (
        output clear, wr_en, wr_addr, din, rd_en, rd_addr,
        input  busy, dout, dout_valid
    );

    modport slave (
        input  clear, wr_en, wr_addr, din, rd_en, rd_addr,
        output busy, dout, dout_valid
    );

endinterface

// File: rtl/bram_core.sv
// Inferred SDP array with a registered read port and optional write-first bypass.
// Latency 1 cycle from re_i to rdata_o; rdata_o holds between reads; no backpressure.
module bram_core
    import bram_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int unsigned DEPTH_L = depth_of(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH_L];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic                  same_addr;

    assign same_addr = we_i && (waddr_i == raddr_i);

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // The array read sees pre-edge contents, so BYPASS=0 naturally returns old data.
    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            if ((BYPASS != 0) && same_addr) begin
                rdata_d = wdata_i;
            end else begin
                rdata_d = mem_q[raddr_i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bram_sdp.sv
// Parametrised SDP table RAM with hardware fill engine, valid tracking and optional output stage.
// Read latency 1+OUT_REG cycles; user reads/writes are dropped (not stalled) while busy is high.
module bram_sdp
    import bram_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 9,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    OUT_REG    = 1,
    parameter int                    BYPASS     = 1,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0
) (
    input logic       clk,
    input logic       rst_n,
    bram_sdp_if.slave bus
);

    fill_state_e           state_q;
    fill_state_e           state_d;
    logic [ADDR_WIDTH-1:0] fill_addr_q;
    logic [ADDR_WIDTH-1:0] fill_addr_d;
    logic                  busy;
    logic                  rd_acc;
    logic                  core_we;
    logic [ADDR_WIDTH-1:0] core_waddr;
    logic [DATA_WIDTH-1:0] core_wdata;
    logic [DATA_WIDTH-1:0] core_rdata;
    logic                  rd_vld_q;
    logic                  rd_vld_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FILL;
            fill_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            fill_addr_q <= fill_addr_d;
        end
    end

    // clear is only looked at in IDLE, so a request during a fill is simply lost.
    always_comb begin
        state_d     = state_q;
        fill_addr_d = fill_addr_q;
        if (state_q == FILL) begin
            fill_addr_d = fill_addr_q + ADDR_WIDTH'(1);
            if (&fill_addr_q) begin
                state_d = IDLE;
            end
        end else if (bus.clear) begin
            state_d     = FILL;
            fill_addr_d = '0;
        end
    end

    assign busy     = (state_q == FILL);
    assign bus.busy = busy;

    assign rd_acc     = bus.rd_en && !busy;
    assign core_we    = rst_n && (busy || bus.wr_en);
    assign core_waddr = busy ? fill_addr_q : bus.wr_addr;
    assign core_wdata = busy ? FILL_VALUE  : bus.din;

    bram_core #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .BYPASS     (BYPASS)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (core_we),
        .waddr_i (core_waddr),
        .wdata_i (core_wdata),
        .re_i    (rd_acc),
        .raddr_i (bus.rd_addr),
        .rdata_o (core_rdata)
    );

    assign rd_vld_d = rd_acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_vld_q <= 1'b0;
        end else begin
            rd_vld_q <= rd_vld_d;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] dout_q;
            logic [DATA_WIDTH-1:0] dout_d;
            logic                  vld_q;

            // Only capture on a real read so dout holds across idle cycles.
            assign dout_d = rd_vld_q ? core_rdata : dout_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    dout_q <= '0;
                    vld_q  <= 1'b0;
                end else begin
                    dout_q <= dout_d;
                    vld_q  <= rd_vld_q;
                end
            end

            assign bus.dout       = dout_q;
            assign bus.dout_valid = vld_q;
        end else begin : g_no_out_reg
            assign bus.dout       = core_rdata;
            assign bus.dout_valid = rd_vld_q;
        end
    endgenerate

endmodule

// File: tb/tb_bram_sdp.sv
// Bench for bram_sdp: instance A (512x8, OUT_REG=1, BYPASS=1, fill 0x00) and
// instance B (16x8, OUT_REG=0, BYPASS=0, fill 0xFF) against a queue-based reference model.
module tb_bram_sdp;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bram_sdp_if #(.ADDR_WIDTH(9), .DATA_WIDTH(8)) ifa ();
    bram_sdp_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) ifb ();

    bram_sdp #(.ADDR_WIDTH(9), .DATA_WIDTH(8), .OUT_REG(1), .BYPASS(1), .FILL_VALUE(8'h00))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    bram_sdp #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .OUT_REG(0), .BYPASS(0), .FILL_VALUE(8'hFF))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    // ---------------- reference model ----------------
    localparam int DEPTH_A = 512;
    localparam int DEPTH_B = 16;
    localparam int LAT_A   = 2;   // 1 + OUT_REG
    localparam int LAT_B   = 1;

    typedef struct { int ready; logic [7:0] d; } rd_t;
    rd_t        q_a[$];
    rd_t        q_b[$];
    logic [7:0] mem_a [DEPTH_A];
    logic [7:0] mem_b [DEPTH_B];
    int         fl_a = DEPTH_A;
    int         fl_b = DEPTH_B;
    int         cyc = 0;
    logic [7:0] last_a = 8'h00, last_b = 8'h00, rdd_a, rdd_b;
    logic       ev_a = 1'b0, ev_b = 1'b0, eb_a = 1'b1, eb_b = 1'b1;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            fl_a = DEPTH_A; q_a.delete(); last_a = 8'h00;
            fl_b = DEPTH_B; q_b.delete(); last_b = 8'h00;
        end else begin
            if (fl_a == 0) begin
                if (ifa.rd_en) begin
                    rdd_a = (ifa.wr_en && ifa.wr_addr == ifa.rd_addr) ? ifa.din : mem_a[ifa.rd_addr];
                    q_a.push_back('{cyc + LAT_A, rdd_a});
                end
                if (ifa.wr_en) mem_a[ifa.wr_addr] = ifa.din;
                if (ifa.clear) fl_a = DEPTH_A;
            end else begin
                mem_a[DEPTH_A - fl_a] = 8'h00;
                fl_a--;
            end
            if (fl_b == 0) begin
                if (ifb.rd_en) begin
                    rdd_b = mem_b[ifb.rd_addr];
                    q_b.push_back('{cyc + LAT_B, rdd_b});
                end
                if (ifb.wr_en) mem_b[ifb.wr_addr] = ifb.din;
                if (ifb.clear) fl_b = DEPTH_B;
            end else begin
                mem_b[DEPTH_B - fl_b] = 8'hFF;
                fl_b--;
            end
        end
        ev_a = 1'b0;
        if (q_a.size() != 0 && q_a[0].ready == cyc + 1) begin
            ev_a = 1'b1; last_a = q_a[0].d; q_a.delete(0);
        end
        ev_b = 1'b0;
        if (q_b.size() != 0 && q_b[0].ready == cyc + 1) begin
            ev_b = 1'b1; last_b = q_b[0].d; q_b.delete(0);
        end
        eb_a = (fl_a != 0);
        eb_b = (fl_b != 0);
    end

    // ---------------- bench plumbing ----------------
    int vec = 0;
    int errs = 0;
    int nba = 0;
    int nbb = 0;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (ifa.busy === 1'b1) nba++;
        if (ifb.busy === 1'b1) nbb++;
    endtask

    task automatic idle_inputs();
        ifa.clear = 0; ifa.wr_en = 0; ifa.wr_addr = '0; ifa.din = '0; ifa.rd_en = 0; ifa.rd_addr = '0;
        ifb.clear = 0; ifb.wr_en = 0; ifb.wr_addr = '0; ifb.din = '0; ifb.rd_en = 0; ifb.rd_addr = '0;
    endtask

    task automatic test_reset();
        int nva, nvb;
        idle_inputs();
        rst_n = 0;
        repeat (3) begin
            tick();
            vec++;
            if (ifa.busy !== 1'b1 || ifa.dout_valid !== 1'b0 || ifa.dout !== 8'h00 ||
                ifb.busy !== 1'b1 || ifb.dout_valid !== 1'b0 || ifb.dout !== 8'h00) begin
                errs++;
                $display("FAIL reset_hold a:busy=%b vld=%b dout=%h b:busy=%b vld=%b dout=%h want busy=1 vld=0 dout=00",
                         ifa.busy, ifa.dout_valid, ifa.dout, ifb.busy, ifb.dout_valid, ifb.dout);
            end
        end
        rst_n = 1;
        nba = (ifa.busy === 1'b1) ? 1 : 0;
        nbb = (ifb.busy === 1'b1) ? 1 : 0;
        for (int i = 0; i < 700 && (ifa.busy === 1'b1 || ifb.busy === 1'b1); i++) begin
            tick();
            vec++;
            if (ifa.busy !== eb_a || ifb.busy !== eb_b) begin
                errs++;
                $display("FAIL reset_fill_busy cyc=%0d a=%b want %b b=%b want %b", cyc, ifa.busy, eb_a, ifb.busy, eb_b);
            end
        end
        vec++;
        if (nba != 512 || nbb != 16) begin
            errs++;
            $display("FAIL reset_fill_len a=%0d want 512 b=%0d want 16", nba, nbb);
        end
        nva = 0; nvb = 0;
        for (int i = 0; i < DEPTH_A + 3; i++) begin
            ifa.rd_en = (i < DEPTH_A); ifa.rd_addr = 9'(i);
            ifb.rd_en = (i < DEPTH_B); ifb.rd_addr = 4'(i);
            tick();
            vec++;
            if (ifa.dout_valid !== ev_a || ifa.dout !== last_a || ifb.dout_valid !== ev_b || ifb.dout !== last_b ||
                (ifa.dout_valid === 1'b1 && ifa.dout !== 8'h00) || (ifb.dout_valid === 1'b1 && ifb.dout !== 8'hFF)) begin
                errs++;
                $display("FAIL reset_readall i=%0d a=%b/%h want %b/%h b=%b/%h want %b/%h",
                         i, ifa.dout_valid, ifa.dout, ev_a, last_a, ifb.dout_valid, ifb.dout, ev_b, last_b);
            end
            if (ifa.dout_valid === 1'b1) nva++;
            if (ifb.dout_valid === 1'b1) nvb++;
        end
        idle_inputs();
        vec++;
        if (nva != DEPTH_A || nvb != DEPTH_B) begin
            errs++;
            $display("FAIL reset_readall_count a=%0d want 512 b=%0d want 16", nva, nvb);
        end
    endtask

    task automatic test_latency();
        ifa.wr_en = 1; ifa.wr_addr = 9'h010; ifa.din = 8'hA5;
        ifb.wr_en = 1; ifb.wr_addr = 4'hA;   ifb.din = 8'hA5;
        tick();
        idle_inputs();
        ifa.rd_en = 1; ifa.rd_addr = 9'h010;
        ifb.rd_en = 1; ifb.rd_addr = 4'hA;
        vec++;
        if (ifa.dout_valid !== 1'b0 || ifb.dout_valid !== 1'b0) begin
            errs++;
            $display("FAIL lat_before a_vld=%b b_vld=%b want 0 0", ifa.dout_valid, ifb.dout_valid);
        end
        tick();   // edge N samples rd_en
        idle_inputs();
        vec++;
        if (ifa.dout_valid !== 1'b0 || ifb.dout_valid !== 1'b1 || ifb.dout !== 8'hA5) begin
            errs++;
            $display("FAIL lat_n1 a_vld=%b want 0 b_vld=%b dout=%h want 1 a5", ifa.dout_valid, ifb.dout_valid, ifb.dout);
        end
        tick();
        vec++;
        if (ifa.dout_valid !== 1'b1 || ifa.dout !== 8'hA5 || ifb.dout_valid !== 1'b0 || ifb.dout !== 8'hA5) begin
            errs++;
            $display("FAIL lat_n2 a=%b/%h want 1/a5 b=%b/%h want 0/a5", ifa.dout_valid, ifa.dout, ifb.dout_valid, ifb.dout);
        end
        tick();
        vec++;
        if (ifa.dout_valid !== 1'b0 || ifa.dout !== 8'hA5) begin
            errs++;
            $display("FAIL lat_n3 a=%b/%h want 0/a5", ifa.dout_valid, ifa.dout);
        end
    endtask

    task automatic test_rdw();
        ifa.wr_en = 1; ifa.wr_addr = 9'h1FF; ifa.din = 8'h11;
        ifb.wr_en = 1; ifb.wr_addr = 4'hF;   ifb.din = 8'h11;
        tick();
        ifa.din = 8'h3C; ifa.rd_en = 1; ifa.rd_addr = 9'h1FF;
        ifb.din = 8'h3C; ifb.rd_en = 1; ifb.rd_addr = 4'hF;
        tick();
        idle_inputs();
        vec++;
        if (ifb.dout_valid !== 1'b1 || ifb.dout !== 8'h11) begin
            errs++;
            $display("FAIL rdw_old b=%b/%h want 1/11", ifb.dout_valid, ifb.dout);
        end
        tick();
        vec++;
        if (ifa.dout_valid !== 1'b1 || ifa.dout !== 8'h3C) begin
            errs++;
            $display("FAIL rdw_new a=%b/%h want 1/3c", ifa.dout_valid, ifa.dout);
        end
        ifa.rd_en = 1; ifa.rd_addr = 9'h1FF;
        ifb.rd_en = 1; ifb.rd_addr = 4'hF;
        tick();
        idle_inputs();
        vec++;
        if (ifb.dout_valid !== 1'b1 || ifb.dout !== 8'h3C) begin
            errs++;
            $display("FAIL rdw_after_b b=%b/%h want 1/3c", ifb.dout_valid, ifb.dout);
        end
        tick();
        vec++;
        if (ifa.dout_valid !== 1'b1 || ifa.dout !== 8'h3C) begin
            errs++;
            $display("FAIL rdw_after_a a=%b/%h want 1/3c", ifa.dout_valid, ifa.dout);
        end
    endtask

    task automatic test_clear();
        ifa.wr_en = 1; ifa.wr_addr = 9'd5; ifa.din = 8'h55;
        tick();
        idle_inputs();
        ifa.clear = 1;
        nba = 0;
        tick();   // clear edge
        ifa.clear = 0;
        vec++;
        if (ifa.busy !== 1'b1) begin
            errs++;
            $display("FAIL clear_busy_rise busy=%b want 1", ifa.busy);
        end
        ifa.wr_en = 1; ifa.wr_addr = 9'd6; ifa.din = 8'h77;
        tick();
        idle_inputs();
        ifa.rd_en = 1; ifa.rd_addr = 9'd5;
        tick();
        idle_inputs();
        repeat (3) begin
            tick();
            vec++;
            if (ifa.dout_valid !== 1'b0) begin
                errs++;
                $display("FAIL clear_read_dropped vld=%b want 0", ifa.dout_valid);
            end
        end
        ifa.clear = 1;
        tick();
        ifa.clear = 0;
        for (int i = 0; i < 700 && ifa.busy === 1'b1; i++) tick();
        vec++;
        if (nba != 512) begin
            errs++;
            $display("FAIL clear_len busy_cycles=%0d want 512", nba);
        end
        ifa.rd_en = 1; ifa.rd_addr = 9'd5;
        tick();
        ifa.rd_addr = 9'd6;
        tick();
        idle_inputs();
        vec++;
        if (ifa.dout_valid !== 1'b1 || ifa.dout !== 8'h00) begin
            errs++;
            $display("FAIL clear_addr5 a=%b/%h want 1/00", ifa.dout_valid, ifa.dout);
        end
        tick();
        vec++;
        if (ifa.dout_valid !== 1'b1 || ifa.dout !== 8'h00) begin
            errs++;
            $display("FAIL clear_addr6 a=%b/%h want 1/00", ifa.dout_valid, ifa.dout);
        end
        tick();
    endtask

    task automatic test_reset_mid_fill();
        ifa.clear = 1; ifb.clear = 1;
        tick();
        idle_inputs();
        repeat (100) tick();   // A's fill counter now at 100
        rst_n = 0;
        repeat (2) begin
            tick();
            vec++;
            if (ifa.dout_valid !== 1'b0 || ifb.dout_valid !== 1'b0 || ifa.busy !== 1'b1 || ifb.busy !== 1'b1) begin
                errs++;
                $display("FAIL midfill_reset vld=%b%b busy=%b%b want 00 11", ifa.dout_valid, ifb.dout_valid, ifa.busy, ifb.busy);
            end
        end
        rst_n = 1;
        nba = (ifa.busy === 1'b1) ? 1 : 0;
        nbb = (ifb.busy === 1'b1) ? 1 : 0;
        for (int i = 0; i < 700 && (ifa.busy === 1'b1 || ifb.busy === 1'b1); i++) tick();
        vec++;
        if (nba != 512 || nbb != 16) begin
            errs++;
            $display("FAIL midfill_len a=%0d want 512 b=%0d want 16", nba, nbb);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] want [3];
        logic [3:0] addr [3];
        want[0] = 8'h3A; want[1] = 8'hC5; want[2] = 8'h3A;
        addr[0] = 4'hF;  addr[1] = 4'h0;  addr[2] = 4'hF;
        ifb.wr_en = 1; ifb.wr_addr = 4'hF; ifb.din = 8'h3A;
        tick();
        ifb.wr_addr = 4'h0; ifb.din = 8'hC5;
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            ifb.rd_en = 1; ifb.rd_addr = addr[i];
            tick();
            vec++;
            if (ifb.dout_valid !== 1'b1 || ifb.dout !== want[i]) begin
                errs++;
                $display("FAIL wrap_read%0d b=%b/%h want 1/%h", i, ifb.dout_valid, ifb.dout, want[i]);
            end
        end
        idle_inputs();
        tick();
        vec++;
        if (ifb.dout_valid !== 1'b0 || ifb.dout !== 8'h3A) begin
            errs++;
            $display("FAIL wrap_after b=%b/%h want 0/3a", ifb.dout_valid, ifb.dout);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            ifa.clear   = ($urandom_range(0, 599) == 0);
            ifa.wr_en   = $urandom_range(0, 1) != 0;
            ifa.wr_addr = ($urandom_range(0, 1) != 0) ? 9'($urandom_range(0, 7)) : 9'($urandom);
            ifa.din     = 8'($urandom);
            ifa.rd_en   = $urandom_range(0, 1) != 0;
            ifa.rd_addr = ($urandom_range(0, 1) != 0) ? 9'($urandom_range(0, 7)) : 9'($urandom);
            ifb.clear   = ($urandom_range(0, 59) == 0);
            ifb.wr_en   = $urandom_range(0, 1) != 0;
            ifb.wr_addr = 4'($urandom);
            ifb.din     = 8'($urandom);
            ifb.rd_en   = $urandom_range(0, 1) != 0;
            ifb.rd_addr = 4'($urandom);
            tick();
            vec++;
            if (ifa.busy !== eb_a || ifa.dout_valid !== ev_a || ifa.dout !== last_a ||
                ifb.busy !== eb_b || ifb.dout_valid !== ev_b || ifb.dout !== last_b) begin
                errs++;
                $display("FAIL random cyc=%0d a:busy=%b/%b vld=%b/%b dout=%h/%h b:busy=%b/%b vld=%b/%b dout=%h/%h",
                         cyc, ifa.busy, eb_a, ifa.dout_valid, ev_a, ifa.dout, last_a,
                         ifb.busy, eb_b, ifb.dout_valid, ev_b, ifb.dout, last_b);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_latency();
        test_rdw();
        test_clear();
        test_reset_mid_fill();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
